id_tokenizer: RTL and testbench

Parametrised streaming identifier/number tokenizer, the successor of the single-bit identifier recogniser FSM. It accepts one character per valid cycle and keeps the per-character `match` flag for the suffix pattern letters+digits+. It also segments the stream into delimiter-separated tokens, classifies each token, reports its length and keeps a running token count. It sits between the character source (UART RX / test stream) and downstream parsing logic.

---
 rtl/id_tok_pkg.sv | 47 ++++
 rtl/id_char_class.sv | 30 +++
 rtl/id_tokenizer.sv | 119 +++++++++++
 tb/tb_id_tokenizer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/id_tok_pkg.sv
// Shared types and constants for the streaming identifier/number tokenizer.
// Character classes, suffix-recogniser states and token type encodings live here.
package id_tok_pkg;

  typedef enum logic [1:0] {
    CC_LETTER = 2'd0,
    CC_DIGIT  = 2'd1,
    CC_UNDER  = 2'd2,
    CC_DELIM  = 2'd3
  } char_class_e;

  typedef enum logic [1:0] {
    S_NONE = 2'd0,
    S_LET  = 2'd1,
    S_DIG  = 2'd2
  } suffix_e;

  // Encodings are visible on the tok_type port, so the values are fixed.
  typedef enum logic [1:0] {
    TOK_IDENT  = 2'd0,
    TOK_NUMBER = 2'd1,
    TOK_BAD    = 2'd2,
    TOK_OVF    = 2'd3
  } tok_type_e;

  localparam logic [7:0] ASCII_UP_A  = 8'h41;
  localparam logic [7:0] ASCII_UP_Z  = 8'h5A;
  localparam logic [7:0] ASCII_LO_A  = 8'h61;
  localparam logic [7:0] ASCII_LO_Z  = 8'h7A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_UNDER = 8'h5F;

  function automatic char_class_e classify_byte(input logic [7:0] b);
    char_class_e cc;
    cc = CC_DELIM;
    if ((b >= ASCII_UP_A && b <= ASCII_UP_Z) || (b >= ASCII_LO_A && b <= ASCII_LO_Z)) begin
      cc = CC_LETTER;
    end else if (b >= ASCII_ZERO && b <= ASCII_NINE) begin
      cc = CC_DIGIT;
    end else if (b == ASCII_UNDER) begin
      cc = CC_UNDER;
    end
    return cc;
  endfunction

endpackage

// File: rtl/id_char_class.sv
// Combinational character classifier. Any nonzero bit above the low byte
// forces DELIM, so wide character sets never alias onto ASCII letters.
module id_char_class
  import id_tok_pkg::*;
#(
  parameter int CHAR_W = 8
) (
  input  logic [CHAR_W-1:0] char_i,
  output char_class_e       class_o
);

  logic [7:0] low_byte;
  logic       high_nz;

  generate
    if (CHAR_W > 8) begin : g_wide
      assign low_byte = char_i[7:0];
      assign high_nz  = |char_i[CHAR_W-1:8];
    end else if (CHAR_W == 8) begin : g_byte
      assign low_byte = char_i;
      assign high_nz  = 1'b0;
    end else begin : g_narrow
      assign low_byte = 8'(char_i);
      assign high_nz  = 1'b0;
    end
  endgenerate

  assign class_o = high_nz ? CC_DELIM : classify_byte(low_byte);

endmodule

// File: rtl/id_tokenizer.sv
// Streaming tokenizer: suffix recogniser for letters+digits+, plus delimiter
// segmentation with token classification, length and a saturating token count.
module id_tokenizer
  import id_tok_pkg::*;
#(
  parameter  int CHAR_W  = 8,
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [CHAR_W-1:0] char,
  output logic              match,
  output logic              tok_valid,
  output logic [1:0]        tok_type,
  output logic [LEN_W-1:0]  tok_len,
  output logic [CNT_W-1:0]  tok_count
);

  // Length saturates one past the legal maximum; that value marks overflow.
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  char_class_e cc;

  id_char_class #(
    .CHAR_W (CHAR_W)
  ) u_char_class (
    .char_i  (char),
    .class_o (cc)
  );

  suffix_e          state_q,     state_d;
  tok_type_e        cls_q,       cls_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic             match_q,     match_d;
  logic             tok_valid_q, tok_valid_d;
  tok_type_e        tok_type_q,  tok_type_d;
  logic [LEN_W-1:0] tok_len_q,   tok_len_d;
  logic [CNT_W-1:0] tok_count_q, tok_count_d;

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d     = state_q;
    cls_d       = cls_q;
    len_d       = len_q;
    match_d     = match_q;
    tok_valid_d = 1'b0;
    tok_type_d  = tok_type_q;
    tok_len_d   = tok_len_q;
    tok_count_d = tok_count_q;

    if (char_valid) begin
      case (cc)
        CC_LETTER: state_d = S_LET;
        CC_DIGIT:  state_d = (state_q == S_NONE) ? S_NONE : S_DIG;
        default:   state_d = S_NONE;
      endcase
      match_d = (state_d == S_DIG);

      if (cc == CC_DELIM) begin
        // A delimiter with nothing accumulated is a no-op beyond the suffix reset.
        if (len_q != '0) begin
          tok_valid_d = 1'b1;
          tok_type_d  = (len_q == LEN_SAT) ? TOK_OVF : cls_q;
          tok_len_d   = (len_q == LEN_SAT) ? LEN_MAX : len_q;
          if (tok_count_q != '1) begin
            tok_count_d = tok_count_q + CNT_W'(1);
          end
          len_d = '0;
          cls_d = TOK_IDENT;
        end
      end else begin
        if (len_q != LEN_SAT) begin
          len_d = len_q + LEN_W'(1);
        end
        if (len_q == '0) begin
          cls_d = (cc == CC_DIGIT) ? TOK_NUMBER : TOK_IDENT;
        end else if (cls_q == TOK_NUMBER && cc != CC_DIGIT) begin
          cls_d = TOK_BAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_NONE;
      cls_q       <= TOK_IDENT;
      len_q       <= '0;
      match_q     <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_type_q  <= TOK_IDENT;
      tok_len_q   <= '0;
      tok_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      len_q       <= len_d;
      match_q     <= match_d;
      tok_valid_q <= tok_valid_d;
      tok_type_q  <= tok_type_d;
      tok_len_q   <= tok_len_d;
      tok_count_q <= tok_count_d;
    end
  end

  assign match     = match_q;
  assign tok_valid = tok_valid_q;
  assign tok_type  = tok_type_q;
  assign tok_len   = tok_len_q;
  assign tok_count = tok_count_q;

endmodule

// File: tb/tb_id_tokenizer.sv
// Directed bench for id_tokenizer: a default instance plus a MAX_LEN=4,
// CNT_W=2 instance fed the same stream for overflow and count saturation.
module tb_id_tokenizer;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic [7:0] ch;

  logic       match,   tok_valid;
  logic [1:0] tok_type;
  logic [4:0] tok_len;
  logic [15:0] tok_count;

  logic       match4,  tok_valid4;
  logic [1:0] tok_type4;
  logic [2:0] tok_len4;
  logic [1:0] tok_count4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_tokenizer dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char       (ch),
    .match      (match),
    .tok_valid  (tok_valid),
    .tok_type   (tok_type),
    .tok_len    (tok_len),
    .tok_count  (tok_count)
  );

  id_tokenizer #(
    .MAX_LEN (4),
    .CNT_W   (2)
  ) dut_m4 (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char       (ch),
    .match      (match4),
    .tok_valid  (tok_valid4),
    .tok_type   (tok_type4),
    .tok_len    (tok_len4),
    .tok_count  (tok_count4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    ch         = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    char_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Non-delimiter char: check suffix flag and that no token is emitted.
  task automatic send_m(input string tag, input logic [7:0] c, input int exp_match);
    send(c);
    check({tag, ".match"}, int'(match), exp_match);
    check({tag, ".tok_valid"}, int'(tok_valid), 0);
  endtask

  // Delimiter closing a token on the default instance.
  task automatic send_tok(input string tag, input logic [7:0] c,
                          input int exp_type, input int exp_len, input int exp_cnt);
    send(c);
    check({tag, ".match"},     int'(match),     0);
    check({tag, ".tok_valid"}, int'(tok_valid), 1);
    check({tag, ".tok_type"},  int'(tok_type),  exp_type);
    check({tag, ".tok_len"},   int'(tok_len),   exp_len);
    check({tag, ".tok_count"}, int'(tok_count), exp_cnt);
  endtask

  task automatic chk_m4(input string tag, input int exp_valid, input int exp_type,
                        input int exp_len, input int exp_cnt);
    check({tag, ".m4.tok_valid"}, int'(tok_valid4), exp_valid);
    check({tag, ".m4.tok_type"},  int'(tok_type4),  exp_type);
    check({tag, ".m4.tok_len"},   int'(tok_len4),   exp_len);
    check({tag, ".m4.tok_count"}, int'(tok_count4), exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    char_valid = 1'b0;
    ch         = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.match",     int'(match),     0);
    check("rst.tok_valid", int'(tok_valid), 0);
    check("rst.tok_type",  int'(tok_type),  0);
    check("rst.tok_len",   int'(tok_len),   0);
    check("rst.tok_count", int'(tok_count), 0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // "AB0123 " -> IDENT len 6; MAX_LEN=4 instance overflows.
    send_m("t1.A", "A", 0);
    send_m("t1.B", "B", 0);
    send_m("t1.0", "0", 1);
    send_m("t1.1", "1", 1);
    send_m("t1.2", "2", 1);
    send_m("t1.3", "3", 1);
    send_tok("t1.sp", 8'h20, 0, 6, 1);
    chk_m4("t1", 1, 3, 4, 1);
    idle();
    check("t1.idle.tok_valid", int'(tok_valid), 0);
    check("t1.idle.tok_len_hold", int'(tok_len), 6);

    // "12a3" + NUL -> BAD len 4; exactly MAX_LEN on the small instance.
    send_m("t2.1", "1", 0);
    send_m("t2.2", "2", 0);
    send_m("t2.a", "a", 0);
    send_m("t2.3", "3", 1);
    send_tok("t2.nul", 8'h00, 2, 4, 2);
    chk_m4("t2", 1, 2, 4, 2);

    // "007  _x9 " -> NUMBER 3, extra space silent, back-to-back IDENT 3.
    send_m("t3.0a", "0", 0);
    send_m("t3.0b", "0", 0);
    send_m("t3.7", "7", 0);
    send_tok("t3.sp1", 8'h20, 1, 3, 3);
    chk_m4("t3a", 1, 1, 3, 3);
    send_m("t3.sp2", 8'h20, 0);
    check("t3.sp2.tok_count", int'(tok_count), 3);
    send_m("t3._", "_", 0);
    send_m("t3.x", "x", 0);
    send_m("t3.9", "9", 1);
    send_tok("t3.sp3", 8'h20, 0, 3, 4);
    chk_m4("t3b", 1, 0, 3, 3);

    // "1a345 " -> BAD len 5 on default; OVF wins over BAD on small instance.
    send_m("t4.1", "1", 0);
    send_m("t4.a", "a", 0);
    send_m("t4.3", "3", 1);
    send_m("t4.4", "4", 1);
    send_m("t4.5", "5", 1);
    send_tok("t4.sp", 8'h20, 2, 5, 5);
    chk_m4("t4", 1, 3, 4, 3);

    // "A", 3 idle cycles, "1", " " -> IDENT len 2.
    send_m("t5.A", "A", 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t5.idle.match", int'(match), 0);
      check("t5.idle.tok_valid", int'(tok_valid), 0);
    end
    send_m("t5.1", "1", 1);
    send_tok("t5.sp", 8'h20, 0, 2, 6);

    // "AB1", then reset together with a valid delimiter: no emission.
    send_m("t6.A", "A", 0);
    send_m("t6.B", "B", 0);
    send_m("t6.1", "1", 1);
    @(negedge clk);
    reset      = 1'b1;
    char_valid = 1'b1;
    ch         = 8'h20;
    @(posedge clk);
    #1;
    check("t6.rst.match",     int'(match),     0);
    check("t6.rst.tok_valid", int'(tok_valid), 0);
    check("t6.rst.tok_type",  int'(tok_type),  0);
    check("t6.rst.tok_len",   int'(tok_len),   0);
    check("t6.rst.tok_count", int'(tok_count), 0);
    chk_m4("t6.rst", 0, 0, 0, 0);
    @(negedge clk);
    reset      = 1'b0;
    char_valid = 1'b0;
    idle();
    send_m("t6.C", "C", 0);
    send_m("t6.2", "2", 1);
    send_tok("t6.sp", 8'h20, 0, 2, 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
